int_adder_result_stage: RTL and testbench

Registered output stage directly downstream of the combinational integer adder. Captures the adder's sum and carry_out, derives the status flags, and presents them on a valid/ready interface. A two-entry skid buffer keeps in_ready purely registered, so there is no combinational path from out_ready back into the adder datapath.

---
 rtl/int_alu_pkg.sv | 21 ++
 rtl/int_flag_gen.sv | 26 ++
 rtl/int_adder_result_stage.sv | 138 +++++++++++++
 tb/tb_int_adder_result_stage.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_alu_pkg.sv
// Shared constants for the integer ALU result path: default width,
// flag bit positions and the result-stage state encoding.
package int_alu_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    // Flag vector layout, shared by the adder and subtract result paths
    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;
    localparam int FLAG_W = 4;

    // Occupancy of the two-entry result buffer
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

endpackage

// File: rtl/int_flag_gen.sv
// Combinational C/Z/N/V flag generator for an add/subtract result.
// The operand MSBs are those of the operands actually summed, so the
// subtract path feeds the inverted B MSB here.
module int_flag_gen
    import int_alu_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] in_sum,
    input  logic                  in_carry,
    input  logic                  in_a_msb,
    input  logic                  in_b_msb,
    output logic [FLAG_W-1:0]     flags
);

    // Derive status flags; overflow means equal-signed operands gave a
    // result of the opposite sign
    always_comb begin
        flags         = '0;
        flags[FLAG_C] = in_carry;
        flags[FLAG_Z] = ~|in_sum;
        flags[FLAG_N] = in_sum[DATA_WIDTH-1];
        flags[FLAG_V] = (in_a_msb == in_b_msb) & (in_sum[DATA_WIDTH-1] != in_a_msb);
    end

endmodule

// File: rtl/int_adder_result_stage.sv
// Registered result stage behind the integer adder. Captures sum and
// flags into a main/skid register pair so in_ready comes straight from
// the state register and out_ready never reaches the adder combinationally.
// Optional feature: INT_ADDER_RESULT_STICKY_EN adds a sticky overflow
// flag (sticky_clr in, sticky_ovf out) that records any drained V=1 beat.
module int_adder_result_stage
    import int_alu_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_sum,
    input  logic                  in_carry,
    input  logic                  in_a_msb,
    input  logic                  in_b_msb,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_sum,
    output logic                  out_carry,
    output logic                  out_zero,
    output logic                  out_neg,
`ifdef INT_ADDER_RESULT_STICKY_EN
    input  logic                  sticky_clr,
    output logic                  sticky_ovf,
`endif
    output logic                  out_ovf
);

    localparam int ENTRY_W = DATA_WIDTH + FLAG_W;

    logic [FLAG_W-1:0]  in_flags;
    logic [ENTRY_W-1:0] in_entry;
    logic [ENTRY_W-1:0] main_q, main_d;
    logic [ENTRY_W-1:0] skid_q, skid_d;
    state_e             state_q, state_d;
    logic               accept;
    logic               drain;

    int_flag_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_flag_gen (
        .in_sum   (in_sum),
        .in_carry (in_carry),
        .in_a_msb (in_a_msb),
        .in_b_msb (in_b_msb),
        .flags    (in_flags)
    );

    assign in_entry  = {in_sum, in_flags};

    // Both handshake indications decode the state register alone
    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = (state_q != ST_TWO);
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    assign out_sum   = main_q[ENTRY_W-1:FLAG_W];
    assign out_carry = main_q[FLAG_C];
    assign out_zero  = main_q[FLAG_Z];
    assign out_neg   = main_q[FLAG_N];
    assign out_ovf   = main_q[FLAG_V];

    // Next-state and register-load decisions for the main/skid pair
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_ONE;
                    main_d  = in_entry;
                end
            end
            ST_ONE: begin
                if (accept && drain) begin
                    main_d = in_entry;
                end else if (accept) begin
                    state_d = ST_TWO;
                    skid_d  = in_entry;
                end else if (drain) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (drain) begin
                    state_d = ST_ONE;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // State and data registers; reset discards both entries at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef INT_ADDER_RESULT_STICKY_EN
    logic sticky_q, sticky_d;

    // A drained overflow beat sets the sticky bit even when clear is asserted
    always_comb begin
        sticky_d = sticky_q;
        if (drain && main_q[FLAG_V]) begin
            sticky_d = 1'b1;
        end else if (sticky_clr) begin
            sticky_d = 1'b0;
        end
    end

    // Sticky overflow register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_ovf = sticky_q;
`endif

endmodule

// File: tb/tb_int_adder_result_stage.sv
// Self-checking bench for int_adder_result_stage. A queue-based model of
// a two-deep FIFO with registered occupancy predicts every output.
// Build with INT_ADDER_RESULT_STICKY_EN defined to cover the sticky flag.
module tb_int_adder_result_stage;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_sum;
    logic         in_carry;
    logic         in_a_msb;
    logic         in_b_msb;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_carry;
    logic         out_zero;
    logic         out_neg;
    logic         out_ovf;
    logic         sticky_clr;
    logic         sticky_exp;
`ifdef INT_ADDER_RESULT_STICKY_EN
    logic         sticky_ovf;
`endif

    typedef struct {
        logic [W-1:0] sum;
        logic         c;
        logic         z;
        logic         n;
        logic         v;
    } beat_t;

    typedef struct {
        logic [W-1:0] sum;
        logic         c;
        logic         am;
        logic         bm;
        logic         ez;
        logic         en;
        logic         ev;
    } vec_t;

    beat_t exp_q[$];
    vec_t  vecs[5];
    int    n_checks;
    int    n_pass;

    int_adder_result_stage #(
        .DATA_WIDTH (W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sum     (in_sum),
        .in_carry   (in_carry),
        .in_a_msb   (in_a_msb),
        .in_b_msb   (in_b_msb),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_carry  (out_carry),
        .out_zero   (out_zero),
        .out_neg    (out_neg),
`ifdef INT_ADDER_RESULT_STICKY_EN
        .sticky_clr (sticky_clr),
        .sticky_ovf (sticky_ovf),
`endif
        .out_ovf    (out_ovf)
    );

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [W-1:0] b2w(input logic b);
        return {{(W-1){1'b0}}, b};
    endfunction

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Outputs predicted from model occupancy; data only while valid
    task automatic checkOutput();
        check("out_valid", b2w(out_valid), b2w(exp_q.size() > 0));
        check("in_ready", b2w(in_ready), b2w(exp_q.size() < 2));
        if (exp_q.size() > 0) begin
            check("out_sum", out_sum, exp_q[0].sum);
            check("out_carry", b2w(out_carry), b2w(exp_q[0].c));
            check("out_zero", b2w(out_zero), b2w(exp_q[0].z));
            check("out_neg", b2w(out_neg), b2w(exp_q[0].n));
            check("out_ovf", b2w(out_ovf), b2w(exp_q[0].v));
        end
`ifdef INT_ADDER_RESULT_STICKY_EN
        check("sticky_ovf", b2w(sticky_ovf), b2w(sticky_exp));
`endif
    endtask

    task automatic checkResetValues(input string tag);
        check({tag, "_out_valid"}, b2w(out_valid), '0);
        check({tag, "_in_ready"}, b2w(in_ready), b2w(1'b1));
        check({tag, "_out_sum"}, out_sum, '0);
        check({tag, "_flags"}, {28'd0, out_carry, out_zero, out_neg, out_ovf}, '0);
`ifdef INT_ADDER_RESULT_STICKY_EN
        check({tag, "_sticky"}, b2w(sticky_ovf), '0);
`endif
    endtask

    // One cycle: drive, check current outputs, clock, then update model
    task automatic applyStimulus(input logic v, input logic [W-1:0] sum, input logic c,
                                 input logic am, input logic bm, input logic ez,
                                 input logic en, input logic ev, input logic ordy,
                                 output logic accepted);
        logic  drn;
        beat_t b;
        in_valid  = v;
        in_sum    = sum;
        in_carry  = c;
        in_a_msb  = am;
        in_b_msb  = bm;
        out_ready = ordy;
        #1;
        checkOutput();
        accepted = v && (exp_q.size() < 2);
        drn      = (exp_q.size() > 0) && ordy;
        if (drn && exp_q[0].v) sticky_exp = 1'b1;
        else if (sticky_clr) sticky_exp = 1'b0;
        @(posedge clk);
        #1;
        if (drn) void'(exp_q.pop_front());
        if (accepted) begin
            b.sum = sum; b.c = c; b.z = ez; b.n = en; b.v = ev;
            exp_q.push_back(b);
        end
    endtask

    // Random operands; flags derived from wide unsigned and signed sums
    task automatic sendRandom(input logic v, input logic ordy, output logic accepted);
        logic [W-1:0] a, b;
        logic [W:0]   s;
        longint       ss;
        logic         ovf;
        a = $urandom;
        b = ($urandom_range(0, 7) == 0) ? (~a + 1) : $urandom;
        s  = {1'b0, a} + {1'b0, b};
        ss = longint'($signed(a)) + longint'($signed(b));
        ovf = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
        applyStimulus(v, s[W-1:0], s[W], a[W-1], b[W-1], s[W-1:0] == 0,
                      s[W-1:0] >= 32'h8000_0000, ovf, ordy, accepted);
    endtask

    initial begin
        logic acc;
        n_checks   = 0;
        n_pass     = 0;
        sticky_clr = 1'b0;
        sticky_exp = 1'b0;
        in_valid   = 1'b0;
        in_sum     = '0;
        in_carry   = 1'b0;
        in_a_msb   = 1'b0;
        in_b_msb   = 1'b0;
        out_ready  = 1'b0;
        rst_n      = 1'b0;

        vecs[0] = '{32'h0000_0005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        $display("[TB] reset with random inputs");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            in_valid  = 1'b1;
            in_sum    = $urandom;
            in_carry  = 1'b1;
            in_a_msb  = $urandom_range(0, 1);
            in_b_msb  = $urandom_range(0, 1);
            out_ready = $urandom_range(0, 1);
            #1;
            checkResetValues("rst");
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checkResetValues("post_rst");
        end

        $display("[TB] streaming table vectors");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, vecs[i].sum, vecs[i].c, vecs[i].am, vecs[i].bm,
                          vecs[i].ez, vecs[i].en, vecs[i].ev, 1'b1, acc);
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, acc);

        $display("[TB] backpressure A B C");
        applyStimulus(1'b1, 32'hA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 32'hB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 32'hC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 32'hC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, acc);
        acc = 1'b0;
        for (int i = 0; i < 5 && !acc; i++) begin
            applyStimulus(1'b1, 32'hC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
        end
        check("c_accepted", b2w(acc), b2w(1'b1));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
        end

        $display("[TB] simultaneous accept and drain");
        for (int i = 0; i < 9; i++) sendRandom(1'b1, 1'b1, acc);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, acc);

`ifdef INT_ADDER_RESULT_STICKY_EN
        $display("[TB] sticky set wins over clear");
        applyStimulus(1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, acc);
        sticky_clr = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
        sticky_clr = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
`endif

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            sticky_clr = ($urandom_range(0, 9) == 0);
            sendRandom($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, acc);
        end
        sticky_clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
        end

        $display("[TB] reset while full");
        sendRandom(1'b1, 1'b0, acc);
        applyStimulus(1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, acc);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, acc);
        check("full_before_reset", b2w(in_ready), '0);
        rst_n = 1'b0;
        #1;
        checkResetValues("mid_rst");
        exp_q.delete();
        sticky_exp = 1'b0;
        @(posedge clk); #1;
        checkResetValues("mid_rst_hold");
        rst_n = 1'b1;
        applyStimulus(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, acc);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
